// File: rtl/sd_stream_sequencer_if.sv
// rtl/sd_stream_sequencer_if.sv - SD block-read reader bus and byte consumer handshake
interface sd_stream_sequencer_if #(
    parameter int ADDR_BITS = 32,
    parameter int IDX_BITS  = 9
);
    logic                 card_configured;
    logic                 block_read_card_ready;
    logic [7:0]           block_read_data_out;
    logic [IDX_BITS-1:0]  block_read_data_idx;
    logic                 block_read_data_new_flag;
    logic                 block_read_trigger;
    logic                 block_read_continous_mode;
    logic [ADDR_BITS-1:0] block_read_block_addr;
    logic                 byte_req;
    logic                 byte_valid;
    logic [7:0]           byte_data;
    logic                 underrun;

    modport master (
        input  card_configured, block_read_card_ready, block_read_data_out,
               block_read_data_idx, block_read_data_new_flag, byte_req,
        output block_read_trigger, block_read_continous_mode, block_read_block_addr,
               byte_valid, byte_data, underrun
    );

    modport slave (
        output card_configured, block_read_card_ready, block_read_data_out,
               block_read_data_idx, block_read_data_new_flag, byte_req,
        input  block_read_trigger, block_read_continous_mode, block_read_block_addr,
               byte_valid, byte_data, underrun
    );
endinterface

// File: rtl/sd_stream_sequencer.sv
// rtl/sd_stream_sequencer.sv - ping-pong prefetch of consecutive SD blocks streamed out byte by byte
module sd_stream_sequencer #(
    parameter int ADDR_BITS   = 32,
    parameter int IDX_BITS    = 9,
    parameter int BLOCK_BYTES = 512
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 stop,
    input  logic [ADDR_BITS-1:0] start_block,
    input  logic [ADDR_BITS-1:0] num_blocks,
    output logic                 busy,
    output logic                 done,
    sd_stream_sequencer_if.master bus
);
    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(BLOCK_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_SLOT,
        S_ISSUE,
        S_FILL,
        S_FINISH
    } state_t;

    state_t               state;
    logic [7:0]           mem [0:2*BLOCK_BYTES-1];
    logic [1:0]           full;
    logic                 fill_bank;
    logic                 rd_bank;
    logic [IDX_BITS-1:0]  rd_ptr;
    logic [ADDR_BITS-1:0] cur_addr;
    logic [ADDR_BITS-1:0] remaining;
    logic                 stop_pending;

    logic fill_wr;
    logic fill_last;
    logic stop_now;

    always_comb begin
        fill_wr   = (state == S_FILL) && bus.block_read_data_new_flag;
        fill_last = fill_wr && (bus.block_read_data_idx == LAST_IDX);
        stop_now  = stop_pending || stop;
    end

    assign bus.block_read_continous_mode = 1'b0;

    // Bytes outside FILL (e.g. a block still arriving after reset) are dropped.
    always_ff @(posedge clk) begin
        if (fill_wr) begin
            mem[{fill_bank, bus.block_read_data_idx}] <= bus.block_read_data_out;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state                     <= S_IDLE;
            full                      <= 2'b00;
            fill_bank                 <= 1'b0;
            rd_bank                   <= 1'b0;
            rd_ptr                    <= '0;
            cur_addr                  <= '0;
            remaining                 <= '0;
            stop_pending              <= 1'b0;
            bus.block_read_trigger    <= 1'b0;
            bus.block_read_block_addr <= '0;
            bus.byte_valid            <= 1'b0;
            bus.byte_data             <= 8'h00;
            bus.underrun              <= 1'b0;
            busy                      <= 1'b0;
            done                      <= 1'b0;
        end else begin
            bus.block_read_trigger <= 1'b0;
            bus.byte_valid         <= 1'b0;
            bus.underrun           <= 1'b0;
            done                   <= 1'b0;

            if (stop && state != S_IDLE) begin
                stop_pending <= 1'b1;
            end

            if (bus.byte_req) begin
                if (full[rd_bank]) begin
                    bus.byte_valid <= 1'b1;
                    bus.byte_data  <= mem[{rd_bank, rd_ptr}];
                    rd_ptr         <= rd_ptr + 1'b1;
                    if (rd_ptr == LAST_IDX) begin
                        full[rd_bank] <= 1'b0;
                        rd_bank       <= ~rd_bank;
                    end
                end else begin
                    bus.underrun <= 1'b1;
                end
            end

            // Filling only targets an empty bank, so this never collides with the drain release.
            if (fill_last) begin
                full[fill_bank] <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    busy         <= start;
                    stop_pending <= 1'b0;
                    if (start) begin
                        cur_addr  <= start_block;
                        remaining <= num_blocks;
                        full      <= 2'b00;
                        fill_bank <= 1'b0;
                        rd_bank   <= 1'b0;
                        rd_ptr    <= '0;
                        state     <= (num_blocks == '0) ? S_FINISH : S_WAIT_SLOT;
                    end
                end
                S_WAIT_SLOT: begin
                    if (stop_now) begin
                        state <= S_FINISH;
                    end else if (bus.card_configured && bus.block_read_card_ready &&
                                 !full[fill_bank]) begin
                        bus.block_read_trigger    <= 1'b1;
                        bus.block_read_block_addr <= cur_addr;
                        state                     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    state <= S_FILL;
                end
                S_FILL: begin
                    if (fill_last) begin
                        fill_bank <= ~fill_bank;
                        cur_addr  <= cur_addr + 1'b1;
                        remaining <= remaining - 1'b1;
                        state     <= (remaining == ADDR_BITS'(1) || stop_now) ? S_FINISH : S_WAIT_SLOT;
                    end
                end
                S_FINISH: begin
                    // An abort discards buffered data; a normal end waits for the consumer.
                    if (stop_now) begin
                        full  <= 2'b00;
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end else if (full == 2'b00) begin
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sd_stream_sequencer.sv
// tb/tb_sd_stream_sequencer.sv - directed/randomized bench for sd_stream_sequencer
module tb_sd_stream_sequencer;
    localparam int AB = 32;
    localparam int IB = 9;
    localparam int BB = 512;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [AB-1:0] start_block = '0;
    logic [AB-1:0] num_blocks = '0;
    logic          busy;
    logic          done;

    sd_stream_sequencer_if #(.ADDR_BITS(AB), .IDX_BITS(IB)) bus ();

    sd_stream_sequencer #(.ADDR_BITS(AB), .IDX_BITS(IB), .BLOCK_BYTES(BB)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .stop        (stop),
        .start_block (start_block),
        .num_blocks  (num_blocks),
        .busy        (busy),
        .done        (done),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [7:0]  got[$];
    logic [31:0] trig_q[$];
    int          n_under = 0;
    int          n_done = 0;
    int          cons_period = 0;
    int          req_total = 0;
    int          req_issued = 0;
    int          ph = 0;
    logic [31:0] rd_addr = '0;
    logic        rd_active = 1'b0;
    int          rd_bytes = 0;

    function automatic logic [7:0] src_byte(logic [31:0] a, int i);
        return 8'((a * 29) + (a >> 11) + i * 7 + (i >> 8) * 53 + 32'h5A);
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_done(int target, int limit, string tag);
        int k = 0;
        while (n_done < target && k < limit) begin step(); k++; end
        chk({tag, "_done_timeout"}, 64'(n_done >= target), 64'd1);
    endtask

    task automatic wait_trig(int target, int limit, string tag);
        int k = 0;
        while (trig_q.size() < target && k < limit) begin step(); k++; end
        chk({tag, "_trig_timeout"}, 64'(trig_q.size() >= target), 64'd1);
    endtask

    task automatic wait_reader_idle(int limit, string tag);
        int k = 0;
        while (rd_active && k < limit) begin step(); k++; end
        chk({tag, "_reader_timeout"}, 64'(rd_active), 64'd0);
    endtask

    task automatic wait_rd_bytes(int target, int limit, string tag);
        int k = 0;
        while (rd_bytes < target && k < limit) begin step(); k++; end
        chk({tag, "_rdbytes_timeout"}, 64'(rd_bytes >= target), 64'd1);
    endtask

    task automatic wait_reqs(int limit, string tag);
        int k = 0;
        while (req_issued < req_total && k < limit) begin step(); k++; end
        chk({tag, "_req_timeout"}, 64'(req_issued >= req_total), 64'd1);
    endtask

    task automatic check_stream(string tag, logic [31:0] a0, int nblk, int base, bit prefix);
        int n;
        int lim;
        int mism;
        logic [31:0] a;
        n    = got.size() - base;
        lim  = (n < nblk * BB) ? n : nblk * BB;
        mism = 0;
        if (prefix) chk({tag, "_len_le"}, 64'(n <= nblk * BB), 64'd1);
        else        chk({tag, "_len"}, 64'(n), 64'(nblk * BB));
        for (int i = 0; i < lim; i++) begin
            a = a0 + 32'(i / BB);
            if (got[base + i] !== src_byte(a, i % BB)) mism++;
        end
        chk({tag, "_mismatches"}, 64'(mism), 64'd0);
    endtask

    task automatic check_reset_outputs(string tag);
        chk({tag, "_trigger"}, 64'(bus.block_read_trigger), 64'd0);
        chk({tag, "_contmode"}, 64'(bus.block_read_continous_mode), 64'd0);
        chk({tag, "_addr"}, 64'(bus.block_read_block_addr), 64'd0);
        chk({tag, "_valid"}, 64'(bus.byte_valid), 64'd0);
        chk({tag, "_data"}, 64'(bus.byte_data), 64'd0);
        chk({tag, "_underrun"}, 64'(bus.underrun), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
    endtask

    // Reader model: one block per trigger, bytes in index order with random gaps.
    initial begin
        bus.card_configured          = 1'b1;
        bus.block_read_card_ready    = 1'b1;
        bus.block_read_data_new_flag = 1'b0;
        bus.block_read_data_out      = 8'h00;
        bus.block_read_data_idx      = '0;
        forever begin
            @(negedge clk);
            if (bus.block_read_trigger) begin
                rd_addr                   = bus.block_read_block_addr;
                rd_active                 = 1'b1;
                bus.block_read_card_ready = 1'b0;
                repeat ($urandom_range(1, 4)) @(negedge clk);
                for (int i = 0; i < BB; i++) begin
                    bus.block_read_data_new_flag = 1'b1;
                    bus.block_read_data_idx      = IB'(i);
                    bus.block_read_data_out      = src_byte(rd_addr, i);
                    rd_bytes++;
                    @(negedge clk);
                    bus.block_read_data_new_flag = 1'b0;
                    repeat ($urandom_range(0, 1)) @(negedge clk);
                end
                bus.block_read_card_ready = 1'b1;
                rd_active                 = 1'b0;
            end
        end
    end

    initial begin
        bus.byte_req = 1'b0;
        forever begin
            @(negedge clk);
            ph++;
            if (req_issued < req_total) begin
                bus.byte_req = 1'b1;
                req_issued++;
            end else if (cons_period != 0 && (ph % cons_period) == 0) begin
                bus.byte_req = 1'b1;
            end else begin
                bus.byte_req = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (bus.byte_valid) got.push_back(bus.byte_data);
            if (bus.underrun) n_under++;
            if (bus.block_read_trigger) trig_q.push_back(bus.block_read_block_addr);
            if (done) n_done++;
        end
    end

    initial begin
        int tb0, gb, db, ub, vb, rb;
        logic [31:0] a;

        repeat (3) step();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        step();

        // Three blocks from 0x100, consumer every 4 cycles.
        tb0 = trig_q.size(); gb = got.size(); db = n_done;
        start = 1'b1; start_block = 32'h100; num_blocks = 32'd3;
        step();
        start = 1'b0;
        chk("t1_busy_after_start", 64'(busy), 64'd1);
        chk("t1_trig_k1", 64'(bus.block_read_trigger), 64'd0);
        step();
        chk("t1_trig_k2", 64'(bus.block_read_trigger), 64'd1);
        chk("t1_trig_addr_k2", 64'(bus.block_read_block_addr), 64'h100);
        cons_period = 4;
        wait_done(db + 1, 20000, "t1");
        cons_period = 0;
        repeat (5) step();
        chk("t1_busy_low", 64'(busy), 64'd0);
        chk("t1_done_count", 64'(n_done - db), 64'd1);
        chk("t1_trig_count", 64'(trig_q.size() - tb0), 64'd3);
        for (int k = 0; k < 3; k++) chk("t1_trig_addr", 64'(trig_q[tb0 + k]), 64'(32'h100 + k));
        check_stream("t1_stream", 32'h100, 3, gb, 1'b0);

        // Zero-length stream.
        tb0 = trig_q.size(); db = n_done;
        start = 1'b1; start_block = $urandom; num_blocks = 32'd0;
        step();
        start = 1'b0;
        chk("t2_done_k1", 64'(done), 64'd0);
        chk("t2_busy_k1", 64'(busy), 64'd1);
        step();
        chk("t2_done_k2", 64'(done), 64'd1);
        repeat (20) step();
        chk("t2_no_trig", 64'(trig_q.size() - tb0), 64'd0);
        chk("t2_done_count", 64'(n_done - db), 64'd1);
        chk("t2_busy_low", 64'(busy), 64'd0);

        // Idle consumer: both banks fill, third trigger waits for bank 0 release.
        wait_reader_idle(5000, "t3");
        a = $urandom;
        tb0 = trig_q.size(); gb = got.size(); db = n_done; ub = n_under;
        start = 1'b1; start_block = a; num_blocks = 32'd4;
        step();
        start = 1'b0;
        req_total += 1;
        repeat (3) step();
        chk("t3_early_underrun", 64'(n_under - ub), 64'd1);
        chk("t3_early_no_valid", 64'(got.size() - gb), 64'd0);
        wait_trig(tb0 + 2, 20000, "t3");
        wait_reader_idle(5000, "t3b");
        repeat (50) step();
        chk("t3_hold_two_triggers", 64'(trig_q.size() - tb0), 64'd2);
        req_total += 511;
        wait_reqs(2000, "t3");
        repeat (10) step();
        chk("t3_still_two_triggers", 64'(trig_q.size() - tb0), 64'd2);
        chk("t3_bytes_511", 64'(got.size() - gb), 64'd511);
        chk("t3_first_byte", 64'(got[gb]), 64'(src_byte(a, 0)));
        req_total += 1;
        wait_trig(tb0 + 3, 20, "t3c");
        chk("t3_third_addr", 64'(trig_q[tb0 + 2]), 64'(a + 32'd2));
        cons_period = $urandom_range(1, 3);
        wait_done(db + 1, 20000, "t3");
        cons_period = 0;
        repeat (5) step();
        chk("t3_trig_count", 64'(trig_q.size() - tb0), 64'd4);
        check_stream("t3_stream", a, 4, gb, 1'b0);

        // Stop during block 2 of 5.
        wait_reader_idle(5000, "t4");
        a = $urandom;
        tb0 = trig_q.size(); gb = got.size(); db = n_done;
        start = 1'b1; start_block = a; num_blocks = 32'd5;
        step();
        start = 1'b0;
        cons_period = 2;
        wait_trig(tb0 + 2, 20000, "t4");
        rb = rd_bytes;
        wait_rd_bytes(rb + 100, 2000, "t4");
        stop = 1'b1;
        step();
        stop = 1'b0;
        wait_done(db + 1, 20000, "t4");
        cons_period = 0;
        repeat (5) step();
        chk("t4_done_count", 64'(n_done - db), 64'd1);
        chk("t4_busy_low", 64'(busy), 64'd0);
        chk("t4_block_completed", 64'(rd_bytes - rb), 64'(BB));
        check_stream("t4_stream", a, 2, gb, 1'b1);
        ub = n_under; vb = got.size();
        req_total += 1;
        repeat (4) step();
        chk("t4_flags_cleared_underrun", 64'(n_under - ub), 64'd1);
        chk("t4_flags_cleared_no_valid", 64'(got.size() - vb), 64'd0);
        repeat (200) step();
        chk("t4_trig_count", 64'(trig_q.size() - tb0), 64'd2);
        chk("t4_trig_addr1", 64'(trig_q[tb0 + 1]), 64'(a + 32'd1));

        // Reset during FILL, then a fresh stream across the address wrap.
        wait_reader_idle(5000, "t5");
        tb0 = trig_q.size();
        start = 1'b1; start_block = $urandom; num_blocks = 32'd5;
        step();
        start = 1'b0;
        wait_trig(tb0 + 1, 100, "t5");
        rb = rd_bytes;
        wait_rd_bytes(rb + 50, 2000, "t5");
        rst_n = 1'b0;
        step();
        check_reset_outputs("t5_midreset");
        rst_n = 1'b1;
        step();
        tb0 = trig_q.size(); gb = got.size(); db = n_done;
        start = 1'b1; start_block = 32'hFFFF_FFFF; num_blocks = 32'd2;
        step();
        start = 1'b0;
        cons_period = 1;
        wait_done(db + 1, 20000, "t5");
        cons_period = 0;
        repeat (5) step();
        chk("t5_trig_count", 64'(trig_q.size() - tb0), 64'd2);
        chk("t5_trig_addr0", 64'(trig_q[tb0]), 64'hFFFF_FFFF);
        chk("t5_trig_addr1_wrap", 64'(trig_q[tb0 + 1]), 64'd0);
        check_stream("t5_stream", 32'hFFFF_FFFF, 2, gb, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
